// File: rtl/tr_step_drive_if.sv
// ---------------------------------------------------------------------------
// tr_step_drive_if
// Bundles the sample/parameter inputs and the stepper-driver outputs of the
// tracking-mode step drive.
//   master : the side producing samples/parameters (host or bench)
//   slave  : the tr_step_drive core
// Signals:
//   data_valid       ADC sample strobe (x valid when high)
//   data_valid_trig  period-update strobe for the pulse generator
//   tr_mode_enable   tracking-mode permit
//   x                ADC sample, unsigned, XW bits
//   x0               target position, signed 32 bits
//   dx1, dx2         dead-band and saturation limits, unsigned
//   K                precomputed offset k*dx1, 33 bits
//   F1, F2           minimum / maximum step frequency in Hz
//   drv_step         step pulse to driver
//   drv_dir          direction, 1 when x >= x0
//   drv_enable_SM    motor enable
//   N                step period in clk cycles, 17 bits
// ---------------------------------------------------------------------------
interface tr_step_drive_if #(
  parameter int XW = 36
);
  logic          data_valid;
  logic          data_valid_trig;
  logic          tr_mode_enable;
  logic [XW-1:0] x;
  logic [31:0]   x0;
  logic [31:0]   dx1;
  logic [31:0]   dx2;
  logic [32:0]   K;
  logic [31:0]   F1;
  logic [31:0]   F2;
  logic          drv_step;
  logic          drv_dir;
  logic          drv_enable_SM;
  logic [16:0]   N;

  modport master (
    output data_valid, data_valid_trig, tr_mode_enable, x, x0, dx1, dx2, K, F1, F2,
    input  drv_step, drv_dir, drv_enable_SM, N
  );

  modport slave (
    input  data_valid, data_valid_trig, tr_mode_enable, x, x0, dx1, dx2, K, F1, F2,
    output drv_step, drv_dir, drv_enable_SM, N
  );
endinterface

// File: rtl/tr_step_drive.sv
// ---------------------------------------------------------------------------
// tr_step_drive
// Tracking-mode stepper drive: a controller turning the position error
// x - x0 into enable, direction and step period N, followed by a 50% duty
// step pulse generator.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  tr_step_drive_if.slave (samples, limits, frequencies in;
//        drv_step / drv_dir / drv_enable_SM / N out)
// One restoring divider (one quotient bit per clk) is shared between the
// slope computation k = (F2-F1)/(dx2-dx1) and the period N = CLK_HZ/f.
// ---------------------------------------------------------------------------
module tr_step_drive #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int          XW     = 36
) (
  input  logic           clk,
  input  logic           rst,
  tr_step_drive_if.slave bus
);

  localparam int          EW      = XW + 2;               // signed error width
  localparam int          DW      = $clog2(CLK_HZ + 1);   // quotient bits for N
  // CLK_HZ left-aligned so its MSB is consumed first by the divider.
  localparam logic [31:0] CLK_DVD = 32'(CLK_HZ) << (32 - DW);
  localparam logic [31:0] N_MAX   = 32'd131071;

  typedef enum logic [1:0] {S_IDLE, S_KDIV, S_CALC, S_NDIV} state_t;

  state_t        state_q, state_d;
  logic [31:0]   dvd_q, dvd_d;       // dividend, quotient shifts in at LSB
  logic [31:0]   dvs_q, dvs_d;
  logic [31:0]   rem_q, rem_d;
  logic [4:0]    div_cnt_q, div_cnt_d;
  logic [31:0]   k_q, k_d;
  logic          k_valid_q, k_valid_d;
  logic [127:0]  prm_q, prm_d;       // F1/F2/dx1/dx2 that k was computed from
  logic [EW-1:0] e_q, e_d;
  logic [16:0]   n_q, n_d;
  logic          dir_q, dir_d;
  logic          en_q, en_d;

  logic [16:0]   shadow_q, shadow_d;
  logic [16:0]   per_q, per_d;
  logic [16:0]   pg_cnt_q, pg_cnt_d;
  logic          run_q, run_d;
  logic          step_q, step_d;

  logic [127:0]  prm_now;
  logic          kick;
  logic [EW-1:0] e_in;
  logic [EW-1:0] dx_w;
  logic [32:0]   rem_sh;
  logic [32:0]   rem_diff;
  logic          ge;
  logic [31:0]   rem_nx;
  logic [31:0]   dvd_nx;
  logic [16:0]   n_sat;
  logic signed [63:0] f_lin;
  logic [31:0]   f_val;

  assign prm_now = {bus.F1, bus.F2, bus.dx1, bus.dx2};
  // Restart the slope divider on any parameter change, or after reset.
  assign kick    = (prm_now != prm_q) || (!k_valid_q && state_q != S_KDIV);

  // Error in EW-bit two's complement; sign bit gives direction.
  assign e_in = {2'b00, bus.x} - {{(EW-32){bus.x0[31]}}, bus.x0};
  assign dx_w = e_q[EW-1] ? ((~e_q) + EW'(1)) : e_q;

  // Restoring divider step. Since rem < dvs, a non-negative difference
  // always fits in 32 bits, so bit 32 of the difference is the borrow.
  assign rem_sh   = {rem_q, dvd_q[31]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};
  assign ge       = ~rem_diff[32];
  assign rem_nx   = ge ? rem_diff[31:0] : rem_sh[31:0];
  assign dvd_nx   = {dvd_q[30:0], ge};
  assign n_sat    = (dvd_nx > N_MAX) ? 17'h1FFFF : dvd_nx[16:0];

  // Step frequency, clamped to [F1, F2].
  always_comb begin
    f_lin = $signed({32'd0, bus.F1})
          + $signed({32'd0, k_q}) * $signed({{(64-EW){1'b0}}, dx_w})
          - $signed({31'd0, bus.K});
    if (dx_w >= EW'(bus.dx2))
      f_val = bus.F2;
    else if (f_lin < $signed({32'd0, bus.F1}))
      f_val = bus.F1;
    else if (f_lin > $signed({32'd0, bus.F2}))
      f_val = bus.F2;
    else
      f_val = f_lin[31:0];
  end

  // Controller next-state logic
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    div_cnt_d = div_cnt_q;
    k_d       = k_q;
    k_valid_d = k_valid_q;
    prm_d     = prm_q;
    e_d       = e_q;
    n_d       = n_q;
    dir_d     = dir_q;
    en_d      = en_q;

    if (state_q == S_KDIV || state_q == S_NDIV) begin
      dvd_d     = dvd_nx;
      rem_d     = rem_nx;
      div_cnt_d = div_cnt_q - 5'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.data_valid && bus.tr_mode_enable) begin
          e_d     = e_in;
          state_d = S_CALC;
        end
      end
      S_KDIV: begin
        if (div_cnt_q == 5'd0) begin
          k_d       = dvd_nx;
          k_valid_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CALC: begin
        if (!bus.tr_mode_enable) begin
          state_d = S_IDLE;
        end else if (dx_w < EW'(bus.dx1)) begin
          // Dead band: stop the motor, keep N, still track direction.
          en_d    = 1'b0;
          dir_d   = ~e_q[EW-1];
          state_d = S_IDLE;
        end else begin
          dvd_d     = CLK_DVD;
          dvs_d     = f_val;
          rem_d     = '0;
          div_cnt_d = 5'(DW - 1);
          state_d   = S_NDIV;
        end
      end
      S_NDIV: begin
        if (!bus.tr_mode_enable) begin
          state_d = S_IDLE;
        end else if (div_cnt_q == 5'd0) begin
          n_d     = n_sat;
          dir_d   = ~e_q[EW-1];
          en_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!bus.tr_mode_enable)
      en_d = 1'b0;

    // The slope divider is not aborted by the mode permit, only restarted
    // by parameter changes, so k is always valid once tracking resumes.
    if (kick) begin
      prm_d     = prm_now;
      k_valid_d = 1'b0;
      dvd_d     = bus.F2 - bus.F1;
      dvs_d     = bus.dx2 - bus.dx1;
      rem_d     = '0;
      div_cnt_d = 5'd31;
      state_d   = S_KDIV;
    end
  end

  // Pulse generator next-state logic. Gating on the next enable makes the
  // step output fall on the same edge as drv_enable_SM.
  always_comb begin
    per_d    = per_q;
    pg_cnt_d = pg_cnt_q;
    run_d    = run_q;
    shadow_d = bus.data_valid_trig ? n_q : shadow_q;
    if (!en_d) begin
      run_d    = 1'b0;
      pg_cnt_d = '0;
    end else if (!run_q || pg_cnt_q == per_q - 17'd1) begin
      // Start or period boundary: adopt the shadow period. While it is
      // below 2 the generator stays idle and re-samples every clk.
      per_d    = shadow_q;
      pg_cnt_d = '0;
      run_d    = (shadow_q >= 17'd2);
    end else begin
      pg_cnt_d = pg_cnt_q + 17'd1;
    end
    step_d = run_d && (pg_cnt_d < (per_d >> 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
      k_q       <= '0;
      k_valid_q <= 1'b0;
      prm_q     <= '0;
      e_q       <= '0;
      n_q       <= '0;
      dir_q     <= 1'b0;
      en_q      <= 1'b0;
      shadow_q  <= '0;
      per_q     <= '0;
      pg_cnt_q  <= '0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      div_cnt_q <= div_cnt_d;
      k_q       <= k_d;
      k_valid_q <= k_valid_d;
      prm_q     <= prm_d;
      e_q       <= e_d;
      n_q       <= n_d;
      dir_q     <= dir_d;
      en_q      <= en_d;
      shadow_q  <= shadow_d;
      per_q     <= per_d;
      pg_cnt_q  <= pg_cnt_d;
      run_q     <= run_d;
      step_q    <= step_d;
    end
  end

  assign bus.drv_step      = step_q;
  assign bus.drv_dir       = dir_q;
  assign bus.drv_enable_SM = en_q;
  assign bus.N             = n_q;

endmodule

// File: tb/tb_tr_step_drive.sv
// ---------------------------------------------------------------------------
// tb_tr_step_drive
// Directed stimulus with hand-computed expectations. Every expected change
// of {drv_enable_SM, drv_dir, N} is queued by the stimulus; a monitor pops
// and compares whenever that output tuple changes. Step waveform widths and
// reset/mode responses are checked inline.
// ---------------------------------------------------------------------------
module tb_tr_step_drive;

  typedef struct packed {
    logic        en;
    logic        dir;
    logic [16:0] n;
  } out_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];

  tr_step_drive_if #(.XW(36)) bus();

  tr_step_drive #(.CLK_HZ(50000000), .XW(36)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Monitor: any change of the output tuple is one transaction.
  initial begin
    out_t prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {bus.drv_enable_SM, bus.drv_dir, bus.N};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update: got en=%0b dir=%0b N=%0d, none expected",
                   cur.en, cur.dir, cur.n);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL update: got en=%0b dir=%0b N=%0d, expected en=%0b dir=%0b N=%0d",
                     cur.en, cur.dir, cur.n, e.en, e.dir, e.n);
          end else begin
            $display("ok update: en=%0b dir=%0b N=%0d", cur.en, cur.dir, cur.n);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok %s: %0d", nm, act);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d updates still pending after %0d clk", nm, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [35:0] xv, input logic [31:0] x0v,
                      input logic en, input logic dir, input int n, input string nm);
    exp_q.push_back({en, dir, 17'(n)});
    @(negedge clk);
    bus.x          = xv;
    bus.x0         = x0v;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    wait_drain(nm);
  endtask

  task automatic trig();
    @(negedge clk);
    bus.data_valid_trig = 1'b1;
    @(negedge clk);
    bus.data_valid_trig = 1'b0;
  endtask

  // Measures the first complete high/low pair that starts after the call.
  task automatic measure(input string nm, input int exp_hi, input int exp_lo);
    int hi, lo, guard;
    hi = 0; lo = 0; guard = 0;
    while (bus.drv_step !== 1'b0 && guard < 20000) begin @(negedge clk); guard++; end
    while (bus.drv_step !== 1'b1 && guard < 20000) begin @(negedge clk); guard++; end
    while (bus.drv_step === 1'b1 && guard < 20000) begin hi++; @(negedge clk); guard++; end
    while (bus.drv_step === 1'b0 && guard < 20000) begin lo++; @(negedge clk); guard++; end
    if (guard >= 20000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no complete step period within 20000 clk", nm);
    end
    chk({nm, "_high"}, hi, exp_hi);
    chk({nm, "_low"}, lo, exp_lo);
  endtask

  initial begin
    int guard;
    rst                 = 1'b1;
    bus.data_valid      = 1'b0;
    bus.data_valid_trig = 1'b0;
    bus.tr_mode_enable  = 1'b1;
    bus.x               = '0;
    bus.x0              = 32'd5;
    bus.F1              = 32'd6000;
    bus.F2              = 32'd50000;
    bus.dx1             = 32'd250;
    bus.dx2             = 32'd555;
    bus.K               = 33'd36000;

    repeat (2) @(negedge clk);
    chk("reset_step", int'(bus.drv_step), 0);
    chk("reset_dir", int'(bus.drv_dir), 0);
    chk("reset_en", int'(bus.drv_enable_SM), 0);
    chk("reset_N", int'(bus.N), 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // Saturation: dx=29995 >= dx2 -> f=F2=50000 -> N=1000
    send(36'd30000, 32'd5, 1'b1, 1'b1, 1000, "saturation");
    trig();
    measure("sat_step", 500, 500);

    // Linear: dx=395 -> f=26880 -> N=1860
    send(36'd400, 32'd5, 1'b1, 1'b1, 1860, "linear");
    trig();
    measure("lin_step", 930, 930);

    // Dead band: dx=95 < dx1 -> enable off, N held
    send(36'd100, 32'd5, 1'b0, 1'b1, 1860, "deadband");
    chk("deadband_step", int'(bus.drv_step), 0);

    // Lower boundary: dx=250 -> f=F1=6000 -> N=8333
    send(36'd255, 32'd5, 1'b1, 1'b1, 8333, "boundary");

    // Negative error: dx=500 -> f=42000 -> N=1190, dir=0
    send(36'd500, 32'd1000, 1'b1, 1'b0, 1190, "negative");
    trig();
    measure("neg_step", 595, 595);

    // Mode drop mid-pulse
    guard = 0;
    while (bus.drv_step !== 1'b1 && guard < 5000) begin @(negedge clk); guard++; end
    chk("mode_pre_step", int'(bus.drv_step), 1);
    exp_q.push_back({1'b0, 1'b0, 17'd1190});
    bus.tr_mode_enable = 1'b0;
    @(negedge clk);
    chk("mode_off_step", int'(bus.drv_step), 0);
    chk("mode_off_en", int'(bus.drv_enable_SM), 0);
    wait_drain("mode_off");

    // Asynchronous reset mid-operation
    bus.tr_mode_enable = 1'b1;
    send(36'd30000, 32'd5, 1'b1, 1'b1, 1000, "pre_reset");
    trig();
    guard = 0;
    while (bus.drv_step !== 1'b1 && guard < 5000) begin @(negedge clk); guard++; end
    exp_q.push_back('0);
    #3 rst = 1'b1;
    #1;
    chk("arst_step", int'(bus.drv_step), 0);
    chk("arst_dir", int'(bus.drv_dir), 0);
    chk("arst_en", int'(bus.drv_enable_SM), 0);
    chk("arst_N", int'(bus.N), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_drain("arst");
    repeat (60) @(negedge clk);

    // k recomputed after reset
    send(36'd30000, 32'd5, 1'b1, 1'b1, 1000, "post_reset");
    trig();
    measure("post_step", 500, 500);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tr_step_drive.md
Name: tr_step_drive

Overview:
- Tracking-mode stepper drive. Combines the TR controller and the TR_pulse step generator.
- The controller compares each ADC sample x with the target x0. From the error it derives three things: motor enable, direction, and a step period N in clock cycles.
- The step frequency is linear in the absolute error between F1 and F2.
- The pulse generator turns N into a 50% duty step waveform for the stepper driver.

Parameters:
- CLK_HZ, 50000000, clock frequency used to convert step frequency into the period N.
- XW, 36, width of the ADC sample x.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; asynchronous, active-high.
- data_valid  in  1  ADC sample strobe; x is valid when high.
- data_valid_trig  in  1  period-update strobe for the pulse generator.
- tr_mode_enable  in  1  tracking-mode permit.
- x  in  36  ADC sample, unsigned.
- x0  in  32  target position, signed.
- dx1  in  32  dead-band limit, unsigned; errors below it disable the motor.
- dx2  in  32  saturation limit, unsigned, greater than dx1; errors at or above it give F2.
- K  in  33  precomputed offset, equal to k*dx1.
- F1  in  32  minimum step frequency in Hz.
- F2  in  32  maximum step frequency in Hz.
- drv_step  out  1  step pulse to the driver.
- drv_dir  out  1  direction: 1 when x >= x0, 0 otherwise.
- drv_enable_SM  out  1  motor enable.
- N  out  17  step period in clk cycles.

Behaviour:
- Reset (async, rst=1):
  - drv_step, drv_dir and drv_enable_SM go to 0; N goes to 0.
  - All counters and divider state clear.
  - Normal operation resumes on the first clk edge after rst falls.
- Slope computation:
  - k = floor((F2-F1)/(dx2-dx1)), computed by a sequential restoring divider after reset.
  - It is recomputed whenever F1, F2, dx1 or dx2 change.
  - Samples that arrive while k is being computed are ignored.
- tr_mode_enable=0:
  - drv_enable_SM=0 on the next clk.
  - drv_dir and N hold their values.
  - Any calculation in progress is aborted.
- Sample acceptance:
  - A sample is accepted on a clk edge with data_valid=1, tr_mode_enable=1 and the controller idle.
  - Samples arriving while a calculation is busy are dropped.
- Error and direction: e = x - x0, computed signed in 38 bits; dx = |e|.
- Dead band: if dx < dx1, then drv_enable_SM=0, N holds, and drv_dir is updated.
- Frequency:
  - Otherwise f = F1 + k*dx - K, computed in 64-bit signed arithmetic.
  - f is clamped to [F1, F2]; if dx >= dx2 then f = F2.
- Period: N = floor(CLK_HZ/f), saturated to 131071, using a sequential divider.
- Output update:
  - When the divider finishes, N, drv_dir and drv_enable_SM=1 update on the same clk.
  - Latency from sample acceptance to output update is at most 40 clk.
- Pulse generator, period loading:
  - A shadow period register loads N on every clk with data_valid_trig=1.
  - The active period P loads from the shadow at each period boundary, i.e. when the counter wraps.
- Pulse generator, waveform:
  - While drv_enable_SM=1 and P >= 2, a counter counts 0..P-1.
  - drv_step=1 for counts 0..floor(P/2)-1 and 0 for the rest of the period.
- Pulse generator, start and stop:
  - When drv_enable_SM rises, counting starts at 0 using the shadow value.
  - When drv_enable_SM=0 or P<2, drv_step=0 on the next clk and the counter clears.
  - A partial pulse is truncated, never stretched.
- A change of N mid-period affects only the next period.

Test Plan:
- Common settings: F1=6000, F2=50000, dx1=250, dx2=555, K=36000, x0=5; k=144 after init.
- Saturation: mode on, x=30000 -> dx=29995 >= dx2 -> drv_enable_SM=1, drv_dir=1, N=1000; drv_step period 1000 clk, high for 500.
- Linear region: x=400 -> dx=395, f=26880 -> N=1860, drv_dir=1; drv_step high 930 clk, low 930 clk.
- Dead band and lower boundary:
  - x=100 -> dx=95 -> drv_enable_SM=0, drv_step low within 1 clk.
  - Boundary x=255 -> dx=250 -> f=6000, N=8333.
- Negative error: x0=1000, x=500 -> dx=500, f=42000 -> N=1190, drv_dir=0.
- Mode and reset:
  - tr_mode_enable drops mid-pulse -> drv_step=0 next clk, drv_enable_SM=0.
  - rst=1 mid-operation -> all outputs 0 immediately.
  - After release, k is recomputed and x=30000 again yields N=1000.
